// File: rtl/hazard_stall_controller.sv
// ID-stage hazard detector: tracks in-flight EXE/MEM writers, raises stall/freeze,
// and sequences IF/ID flushes after taken branches.
module hazard_stall_controller #(
   parameter int REG_ADDR_W          = 5,
   parameter int BRANCH_FLUSH_CYCLES = 1,
   parameter int CNT_W               = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_uses_src2,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_wb_en,
   input  logic                  id_mem_read,
   input  logic                  forward_en,
   input  logic                  branch_taken,
   output logic                  hazard_detected,
   output logic                  pc_freeze,
   output logic                  ifid_flush,
   output logic [CNT_W-1:0]      stall_count
);

   typedef enum logic {IDLE, FLUSH} state_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

   // The WB-stage entry retires while the register file writes in the first half-cycle,
   // so it can never cause a hazard and only the EXE and MEM entries are held.
   logic                  exe_v_q, exe_v_d, exe_wb_q, exe_wb_d, exe_ld_q, exe_ld_d;
   logic [REG_ADDR_W-1:0] exe_dest_q, exe_dest_d;
   logic                  mem_v_q, mem_wb_q;
   logic [REG_ADDR_W-1:0] mem_dest_q;
   state_t                state_q, state_d;
   logic [2:0]            flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]      stall_count_q, stall_count_d;
   logic                  m_exe, m_mem, raw, flush_now, haz_now;

   function automatic logic slot_match(input logic v, input logic wb,
                                       input logic [REG_ADDR_W-1:0] dest,
                                       input logic [REG_ADDR_W-1:0] s1,
                                       input logic [REG_ADDR_W-1:0] s2,
                                       input logic use2);
      logic hit1, hit2;
      hit1 = (dest == s1) && (s1 != '0);
      hit2 = use2 && (dest == s2) && (s2 != '0);
      return v && wb && (hit1 || hit2);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   always_comb begin
      m_exe     = slot_match(exe_v_q, exe_wb_q, exe_dest_q, id_src1, id_src2, id_uses_src2);
      m_mem     = slot_match(mem_v_q, mem_wb_q, mem_dest_q, id_src1, id_src2, id_uses_src2);
      raw       = forward_en ? (exe_ld_q & m_exe) : (m_exe | m_mem);
      flush_now = ~rst & (branch_taken | (state_q == FLUSH));
      haz_now   = id_valid & raw & ~flush_now & ~rst;
   end

   assign hazard_detected = haz_now;
   assign pc_freeze       = haz_now;
   assign ifid_flush      = flush_now;
   assign stall_count     = stall_count_q;

   always_comb begin
      exe_v_d    = id_valid;
      exe_wb_d   = id_wb_en;
      exe_ld_d   = id_mem_read;
      exe_dest_d = id_dest;
      if (haz_now || flush_now) begin
         exe_v_d    = 1'b0;
         exe_wb_d   = 1'b0;
         exe_ld_d   = 1'b0;
         exe_dest_d = '0;
      end
   end

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      stall_count_d = haz_now ? sat_inc(stall_count_q) : stall_count_q;
      case (state_q)
         IDLE: begin
            if (branch_taken) begin
               flush_cnt_d = FLUSH_RELOAD;
               if (FLUSH_RELOAD != 3'd0) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (branch_taken) begin
               flush_cnt_d = FLUSH_RELOAD;
               if (FLUSH_RELOAD == 3'd0) state_d = IDLE;
            end else if (flush_cnt_q <= 3'd1) begin
               flush_cnt_d = 3'd0;
               state_d     = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            flush_cnt_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_v_q       <= 1'b0;
         exe_wb_q      <= 1'b0;
         exe_ld_q      <= 1'b0;
         mem_v_q       <= 1'b0;
         mem_wb_q      <= 1'b0;
         state_q       <= IDLE;
         flush_cnt_q   <= 3'd0;
         stall_count_q <= '0;
      end else begin
         exe_v_q       <= exe_v_d;
         exe_wb_q      <= exe_wb_d;
         exe_ld_q      <= exe_ld_d;
         mem_v_q       <= exe_v_q;
         mem_wb_q      <= exe_wb_q;
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Register indices are qualified by the valid bits, so they carry no reset.
   always_ff @(posedge clk) begin
      exe_dest_q <= exe_dest_d;
      mem_dest_q <= exe_dest_q;
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed plus randomized bench for hazard_stall_controller, checked against an
// instruction-history reference model.
module tb_hazard_stall_controller;

   localparam int RW  = 5;
   localparam int BFC = 2;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0, id_uses_src2 = 1'b0, id_wb_en = 1'b0, id_mem_read = 1'b0;
   logic [RW-1:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic          forward_en = 1'b0, branch_taken = 1'b0;
   logic          hazard_detected, pc_freeze, ifid_flush;
   logic [CW-1:0] stall_count;

   hazard_stall_controller #(.REG_ADDR_W(RW), .BRANCH_FLUSH_CYCLES(BFC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_uses_src2(id_uses_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_read(id_mem_read), .forward_en(forward_en), .branch_taken(branch_taken),
      .hazard_detected(hazard_detected), .pc_freeze(pc_freeze), .ifid_flush(ifid_flush),
      .stall_count(stall_count));

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      bit [RW-1:0] dest;
      bit          wb;
      bit          ld;
   } instr_t;

   // Model: instructions that left ID in the last two cycles, youngest first.
   instr_t inflight[$];
   int     flush_left = 0;
   int     model_cnt  = 0;
   bit     cnt_known  = 0;
   bit     exp_h, exp_f;
   logic   h_obs, f_obs;
   logic [CW-1:0] cnt_obs;
   int     checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads_result(input instr_t w);
      if (!(w.v && w.wb) || w.dest == 0) return 0;
      return (w.dest == id_src1) || (id_uses_src2 && w.dest == id_src2);
   endfunction

   task automatic cycle();
      bit raw;
      instr_t nxt;
      @(negedge clk);
      raw = 0;
      if (forward_en) begin
         if (inflight.size() > 0 && inflight[0].ld && reads_result(inflight[0])) raw = 1;
      end else begin
         foreach (inflight[i]) if (reads_result(inflight[i])) raw = 1;
      end
      exp_f = !rst && (branch_taken || flush_left > 0);
      exp_h = !rst && id_valid && raw && !exp_f;
      h_obs = hazard_detected;
      f_obs = ifid_flush;
      cnt_obs = stall_count;
      chk("hazard", {31'd0, hazard_detected}, {31'd0, exp_h});
      chk("pc_freeze", {31'd0, pc_freeze}, {31'd0, exp_h});
      chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, exp_f});
      if (cnt_known) chk("stall_count", {28'd0, stall_count}, model_cnt);
      @(posedge clk);
      if (rst) begin
         inflight.delete();
         flush_left = 0;
         model_cnt  = 0;
         cnt_known  = 1;
      end else begin
         if (exp_h || exp_f) nxt = '{0, 0, 0, 0};
         else nxt = '{id_valid, id_dest, id_wb_en, id_mem_read};
         inflight.push_front(nxt);
         if (inflight.size() > 2) void'(inflight.pop_back());
         if (branch_taken) flush_left = BFC - 1;
         else if (flush_left > 0) flush_left--;
         if (exp_h && model_cnt < (1 << CW) - 1) model_cnt++;
      end
      #1;
   endtask

   task automatic set_id(input bit v, input int d, input int s1, input int s2,
                         input bit u2, input bit wb, input bit ld);
      id_valid = v; id_dest = RW'(d); id_src1 = RW'(s1); id_src2 = RW'(s2);
      id_uses_src2 = u2; id_wb_en = wb; id_mem_read = ld;
   endtask

   initial begin
      bit prev_h;
      // reset and empty-scoreboard instruction
      cycle(); cycle();
      rst = 1'b0;
      set_id(1, 3, 1, 2, 1, 1, 0);
      cycle();
      chk("t1_no_hazard", {31'd0, h_obs}, 32'd0);
      chk("t1_cnt_zero", {28'd0, cnt_obs}, 32'd0);

      // RAW without forwarding: two stall cycles
      set_id(1, 4, 1, 2, 1, 1, 0);
      cycle();
      set_id(1, 7, 4, 5, 1, 1, 0);
      cycle(); chk("t2_stall1", {31'd0, h_obs}, 32'd1);
      cycle(); chk("t2_stall2", {31'd0, h_obs}, 32'd1);
      cycle(); chk("t2_release", {31'd0, h_obs}, 32'd0);
      chk("t2_cnt", {28'd0, cnt_obs}, 32'd2);

      // forwarding: load-use stalls once, ALU result does not
      forward_en = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0);
      cycle(); cycle();
      set_id(1, 6, 1, 2, 1, 1, 1);
      cycle();
      set_id(1, 8, 6, 1, 1, 1, 0);
      cycle(); chk("t3_loaduse", {31'd0, h_obs}, 32'd1);
      cycle(); chk("t3_loaduse_rel", {31'd0, h_obs}, 32'd0);
      set_id(1, 6, 1, 2, 1, 1, 0);
      cycle();
      set_id(1, 9, 6, 6, 1, 1, 0);
      cycle(); chk("t3_fwd_alu", {31'd0, h_obs}, 32'd0);

      // r0 and unused src2 never hazard
      forward_en = 1'b0;
      set_id(1, 0, 1, 2, 1, 1, 0);
      cycle();
      set_id(1, 5, 0, 0, 1, 1, 0);
      cycle(); chk("t4_r0", {31'd0, h_obs}, 32'd0);
      set_id(1, 10, 1, 2, 1, 1, 0);
      cycle();
      set_id(1, 11, 1, 10, 0, 1, 0);
      cycle(); chk("t4_nosrc2", {31'd0, h_obs}, 32'd0);

      // branch flush overrides a pending hazard and injects bubbles
      set_id(1, 11, 1, 2, 1, 1, 0);
      cycle();
      set_id(1, 11, 11, 0, 0, 1, 0);
      branch_taken = 1'b1;
      cycle(); chk("t5_flush1", {31'd0, f_obs}, 32'd1);
      chk("t5_masked1", {31'd0, h_obs}, 32'd0);
      branch_taken = 1'b0;
      cycle(); chk("t5_flush2", {31'd0, f_obs}, 32'd1);
      chk("t5_masked2", {31'd0, h_obs}, 32'd0);
      cycle(); chk("t5_flush_end", {31'd0, f_obs}, 32'd0);
      chk("t5_bubble", {31'd0, h_obs}, 32'd0);

      // saturation, then reset in the middle of a stall
      set_id(1, 13, 13, 0, 0, 1, 0);
      for (int i = 0; i < 30; i++) cycle();
      chk("t6_saturate", {28'd0, cnt_obs}, 32'd15);
      prev_h = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (h_obs && !prev_h) break;
         prev_h = h_obs;
      end
      chk("t6_stall_found", {31'd0, h_obs}, 32'd1);
      rst = 1'b1;
      cycle(); chk("t6_rst_haz", {31'd0, h_obs}, 32'd0);
      chk("t6_rst_flush", {31'd0, f_obs}, 32'd0);
      rst = 1'b0;
      cycle(); chk("t6_rst_cnt", {28'd0, cnt_obs}, 32'd0);

      // randomized traffic, small register range for frequent dependences
      for (int i = 0; i < 600; i++) begin
         set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0);
         forward_en   = ($urandom_range(0, 1) == 1);
         branch_taken = ($urandom_range(0, 9) == 0);
         rst          = ($urandom_range(0, 49) == 0);
         if (i % 150 == 0) rst = 1'b1;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
